mux8_rr_tx: RTL and testbench
=============================

// Module: mux8_rr_tx
// PURPOSE
//  8:1 time-division transmit multiplexer; the sending end of the 1:8 demux path.
//  Eight producer lanes compete through a round-robin arbiter. One registered word
//  leaves per accepted cycle, tagged with out_sel, the channel id the far-end
//  demux1_8 uses as its select. Valid/ready handshakes on every lane and on the output.
// PARAMETERS
//  DATA_W  8   width of each lane word and of out_data
//  CNT_W   16  width of the xfer_count statistics counter
// PORTS
//  clk        in   1         single clock; all state updates on its rising edge
//  rst        in   1         synchronous, active-high reset
//  in_valid   in   8         lane i has a word to send
//  in_data    in   8*DATA_W  lane i word at [i*DATA_W +: DATA_W]
//  in_ready   out  8         one-hot-or-zero; lane i word is taken this cycle
//  out_valid  out  1         out_data/out_sel hold a word
//  out_ready  in   1         downstream accepts the word this cycle
//  out_data   out  DATA_W    muxed word
//  out_sel    out  3         source lane id of out_data (demux select)
//  xfer_count out  CNT_W     number of completed output transfers
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_sel=0, xfer_count=0, rr pointer ptr=0.
//    Any held output word is discarded. in_ready=0 while rst=1.
//  - load = !out_valid | out_ready. This allows back-to-back flow at 1 word/cycle.
//  - Grant (combinational): when load=1 and |in_valid, grant = first i with
//    in_valid[i]=1, searching ptr, ptr+1, ..., ptr+7 mod 8.
//    in_ready[grant]=1; all other in_ready=0. When load=0 or no valid lane, in_ready=0.
//  - On a clock edge with load=1 and a grant:
//    out_data <= lane[grant]; out_sel <= grant; out_valid <= 1; ptr <= (grant+1) mod 8.
//  - On a clock edge with load=1 and no valid lane: out_valid <= 0.
//    out_data, out_sel and ptr hold.
//  - load=0 (out_valid=1 and out_ready=0): all outputs and ptr hold. Lane stalls.
//  - Latency: 1 cycle from in_valid&in_ready to out_valid.
//  - Handshake rules:
//    - A producer holds in_valid and its data until in_ready. in_ready never depends on in_data.
//    - out_valid is never dropped before out_ready, and out_data/out_sel are stable while stalled.
//  - Fairness: a lane with in_valid held continuously is granted within 8 loads.
//  - ptr wraps 7 -> 0. A grant on lane 7 sets ptr=0.
//  - xfer_count += 1 on every edge with out_valid&out_ready; wraps at 2^CNT_W-1 -> 0.
//  - Simultaneous out_ready and new grant in the same cycle: the old word completes
//    (counted) and the new word loads; there is no bubble.
// TESTING
//  T1 reset: assert rst 2 cycles with in_valid=8'hFF.
//     -> in_ready=0, out_valid=0, out_sel=0, xfer_count=0.
//  T2 single lane: in_valid=8'h08, lane3=8'hA5, out_ready=1.
//     -> in_ready=8'h08; next cycle out_valid=1, out_data=8'hA5, out_sel=3; ptr=4.
//  T3 round robin: in_valid=8'hFF held, lane i=8'h10+i, out_ready=1 for 10 cycles.
//     -> out_sel 0,1,...,7,0,1; xfer_count=10 one cycle after the last grant.
//  T4 backpressure: word out_sel=5 held, out_ready=0 for 4 cycles with in_valid=8'hFF.
//     -> in_ready=0, out_data/out_sel stable. On out_ready=1, out_sel=6 next cycle.
//  T5 wrap/skip: ptr=6, in_valid=8'h81.
//     -> grant lane 7, then lane 0, then lane 7 again (ptr wrap).
//  T6 reset mid-stream: rst=1 while out_valid=1 and out_ready=0.
//     -> next cycle out_valid=0, xfer_count=0. After release, the first grant searches from lane 0.

Source files
------------

// File: rtl/mux8_rr_tx.sv
// mux8_rr_tx: 8:1 round-robin transmit multiplexer.
// Eight valid/ready producer lanes are arbitrated round-robin. Each accepted word
// is registered onto a single valid/ready output together with its source lane id
// (out_sel), which the far-end 1:8 demux uses as its select.
module mux8_rr_tx #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          in_valid,
  input  logic [8*DATA_W-1:0] in_data,
  output logic [7:0]          in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [2:0]          out_sel,
  output logic [CNT_W-1:0]    xfer_count
);

  // Round-robin pointer: the lane searched first on the next load.
  logic [2:0]        ptr;
  logic              load;
  logic              grant_found;
  logic [2:0]        grant_idx;
  logic [DATA_W-1:0] lane_word;

  // Arbitration: first valid lane at or after ptr (mod 8), only when the output can take a word.
  always_comb begin
    load        = !out_valid || out_ready;
    grant_found = 1'b0;
    grant_idx   = 3'd0;
    for (int k = 0; k < 8; k++) begin
      logic [2:0] idx;
      idx = ptr + 3'(k);
      if (!grant_found && in_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
    in_ready = 8'd0;
    if (!rst && load && grant_found) begin
      in_ready[grant_idx] = 1'b1;
    end
    lane_word = in_data[grant_idx*DATA_W +: DATA_W];
  end

  // Output register, pointer advance and transfer statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= 3'd0;
      ptr        <= 3'd0;
      xfer_count <= '0;
    end else begin
      // The outgoing word completes on the same edge a new one may load, so no bubble.
      if (out_valid && out_ready) begin
        xfer_count <= xfer_count + 1'b1;
      end
      if (load) begin
        if (grant_found) begin
          out_data  <= lane_word;
          out_sel   <= grant_idx;
          out_valid <= 1'b1;
          ptr       <= grant_idx + 3'd1;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux8_rr_tx.sv
// Directed self-checking bench for mux8_rr_tx.
module tb_mux8_rr_tx;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic [7:0]          in_valid;
  logic [8*DATA_W-1:0] in_data;
  logic [7:0]          in_ready;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_data;
  logic [2:0]          out_sel;
  logic [CNT_W-1:0]    xfer_count;

  int tests  = 0;
  int failed = 0;

  mux8_rr_tx #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sel    (out_sel),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes_default();
    for (int i = 0; i < 8; i++) in_data[i*DATA_W +: DATA_W] = 8'h10 + 8'(i);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 8'hFF;
    out_ready = 1'b1;
    set_lanes_default();

    // T1 reset held two cycles with every lane valid
    tick();
    tick();
    chk("t1_in_ready", 32'(in_ready), 32'h00);
    chk("t1_out_valid", 32'(out_valid), 32'h0);
    chk("t1_out_sel", 32'(out_sel), 32'h0);
    chk("t1_out_data", 32'(out_data), 32'h00);
    chk("t1_xfer_count", 32'(xfer_count), 32'h0);

    // T2 single lane 3
    rst = 1'b0;
    in_valid = 8'h08;
    in_data[3*DATA_W +: DATA_W] = 8'hA5;
    #1;
    chk("t2_in_ready", 32'(in_ready), 32'h08);
    tick();
    chk("t2_out_valid", 32'(out_valid), 32'h1);
    chk("t2_out_data", 32'(out_data), 32'hA5);
    chk("t2_out_sel", 32'(out_sel), 32'h3);
    in_valid = 8'h00;
    #1;
    chk("t2_idle_in_ready", 32'(in_ready), 32'h00);
    tick();
    chk("t2_drain_out_valid", 32'(out_valid), 32'h0);
    chk("t2_drain_xfer_count", 32'(xfer_count), 32'h1);
    chk("t2_hold_out_sel", 32'(out_sel), 32'h3);
    chk("t2_hold_out_data", 32'(out_data), 32'hA5);
    // ptr must now be 4: with all lanes valid, lane 4 is granted
    in_valid = 8'hFF;
    #1;
    chk("t2_ptr_is_4", 32'(in_ready), 32'h10);
    rst = 1'b1;
    #1;
    chk("t2_rst_gates_ready", 32'(in_ready), 32'h00);
    tick();
    chk("t2_rst_xfer_count", 32'(xfer_count), 32'h0);

    // T3 round robin over all lanes for 10 grants
    rst = 1'b0;
    set_lanes_default();
    in_valid = 8'hFF;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("t3_in_ready_%0d", i), 32'(in_ready), 32'(8'h01 << (i % 8)));
      tick();
      chk($sformatf("t3_out_sel_%0d", i), 32'(out_sel), 32'(i % 8));
      chk($sformatf("t3_out_data_%0d", i), 32'(out_data), 32'(8'h10 + (i % 8)));
      chk($sformatf("t3_out_valid_%0d", i), 32'(out_valid), 32'h1);
    end
    in_valid = 8'h00;
    tick();
    chk("t3_xfer_count", 32'(xfer_count), 32'd10);
    chk("t3_out_valid_idle", 32'(out_valid), 32'h0);

    // T4 backpressure on a lane-5 word (ptr is 2 here)
    in_valid = 8'h20;
    #1;
    chk("t4_in_ready_load", 32'(in_ready), 32'h20);
    tick();
    chk("t4_out_sel_load", 32'(out_sel), 32'h5);
    out_ready = 1'b0;
    in_valid = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t4_stall_in_ready_%0d", i), 32'(in_ready), 32'h00);
      tick();
      chk($sformatf("t4_stall_out_sel_%0d", i), 32'(out_sel), 32'h5);
      chk($sformatf("t4_stall_out_data_%0d", i), 32'(out_data), 32'h15);
      chk($sformatf("t4_stall_out_valid_%0d", i), 32'(out_valid), 32'h1);
    end
    chk("t4_stall_xfer_count", 32'(xfer_count), 32'd10);
    out_ready = 1'b1;
    #1;
    chk("t4_release_in_ready", 32'(in_ready), 32'h40);
    tick();
    chk("t4_release_out_sel", 32'(out_sel), 32'h6);
    chk("t4_release_xfer_count", 32'(xfer_count), 32'd11);

    // T5 wrap/skip: bring ptr to 6, then only lanes 7 and 0 valid
    in_valid = 8'h20;
    tick();
    chk("t5_prep_out_sel", 32'(out_sel), 32'h5);
    in_valid = 8'h81;
    #1;
    chk("t5_in_ready_a", 32'(in_ready), 32'h80);
    tick();
    chk("t5_out_sel_a", 32'(out_sel), 32'h7);
    #1;
    chk("t5_in_ready_b", 32'(in_ready), 32'h01);
    tick();
    chk("t5_out_sel_b", 32'(out_sel), 32'h0);
    chk("t5_out_data_b", 32'(out_data), 32'h10);
    #1;
    chk("t5_in_ready_c", 32'(in_ready), 32'h80);
    tick();
    chk("t5_out_sel_c", 32'(out_sel), 32'h7);
    chk("t5_out_data_c", 32'(out_data), 32'h17);
    chk("t5_xfer_count", 32'(xfer_count), 32'd15);

    // T6 reset while a word is stalled; ptr is moved to 4 first
    in_valid = 8'h08;
    tick();
    chk("t6_prep_out_sel", 32'(out_sel), 32'h3);
    chk("t6_prep_xfer_count", 32'(xfer_count), 32'd16);
    out_ready = 1'b0;
    in_valid = 8'hFF;
    tick();
    chk("t6_stalled_out_valid", 32'(out_valid), 32'h1);
    rst = 1'b1;
    tick();
    chk("t6_rst_out_valid", 32'(out_valid), 32'h0);
    chk("t6_rst_xfer_count", 32'(xfer_count), 32'h0);
    chk("t6_rst_out_sel", 32'(out_sel), 32'h0);
    rst = 1'b0;
    out_ready = 1'b1;
    in_valid = 8'h82;
    #1;
    chk("t6_first_in_ready", 32'(in_ready), 32'h02);
    tick();
    chk("t6_first_out_sel", 32'(out_sel), 32'h1);
    chk("t6_first_out_data", 32'(out_data), 32'h11);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
